// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and width helper for the staggered reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Smallest unsigned width whose all-ones value covers max_val.
    function automatic int cnt_width(input longint max_val);
        int w;
        w = 1;
        while (((64'd1 << w) - 64'd1) < 64'(max_val)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - staggered multi-channel reset sequencer with runtime re-trigger
// Optional watchdog re-trigger in DONE when RESET_SEQ_WDOG_EN is defined.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 30,
    parameter int DELAY   = 10000,
    parameter int PULSE   = 10000,
    parameter int STAGGER = 1000,
    parameter int WDOG    = 1000000
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            EN,
    input  logic            req,
    input  logic            kick,
    output logic [N_CH-1:0] rst,
    output logic            busy,
    output logic            done
);

    localparam int REL_SPAN = PULSE + (N_CH - 1) * STAGGER;
    localparam int MAX_CNT  = (DELAY > REL_SPAN) ? DELAY : REL_SPAN;

    if (CNT_W < cnt_width(MAX_CNT)) begin : g_cnt_w_check
        $error("reset_seq: CNT_W too narrow for DELAY/PULSE/STAGGER");
    end

    // The hold-off spans DELAY full cycles counted from the first enabled edge.
    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] LAST_END  = CNT_W'((N_CH - 1) * STAGGER - 1);
    localparam logic [N_CH-1:0]  ALL_ON    = {N_CH{1'b1}};
    localparam bit               FAST_DONE = (STAGGER == 0) || (N_CH == 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   rst_q, rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wd_fire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == DELAY_END) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    rst_d   = ALL_ON;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_END) begin
                    cnt_d = '0;
                    if (FAST_DONE) begin
                        state_d = DONE;
                        rst_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = RELEASE;
                        rst_d[0] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                for (int k = 1; k < N_CH; k++) begin
                    if (cnt_q == CNT_W'(k * STAGGER - 1)) begin
                        rst_d[k] = 1'b0;
                    end
                end
                // Counter is left frozen once DONE is reached.
                if (cnt_q == LAST_END) begin
                    state_d = DONE;
                    rst_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (req || wd_fire) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    rst_d   = ALL_ON;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = '0;
                rst_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Disable clears exactly like reset so no channel is driven while off.
    always_ff @(posedge clk_in) begin
        if (!rst_n || !EN) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef RESET_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_END = CNT_W'(WDOG - 1);

    logic [CNT_W-1:0] wd_q, wd_d;

    assign wd_fire = (state_q == DONE) && !kick && (wd_q == WDOG_END);

    always_comb begin
        wd_d = '0;
        if ((state_q == DONE) && !req && !kick && !wd_fire) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n || !EN) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_kick;
    assign unused_kick = kick;
    assign wd_fire     = 1'b0;
`endif

    assign rst  = rst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb/tb_reset_seq.sv - scoreboard bench for reset_seq (N_CH=3, DELAY=8, PULSE=5, STAGGER=2, WDOG=20)
module tb_reset_seq;

    localparam int N_CH    = 3;
    localparam int CNT_W   = 8;
    localparam int DELAY   = 8;
    localparam int PULSE   = 5;
    localparam int STAGGER = 2;
    localparam int WDOG    = 20;

    typedef struct packed {
        logic [N_CH-1:0] rst;
        logic            busy;
        logic            done;
    } exp_t;

    logic            clk_in = 1'b0;
    logic            rst_n;
    logic            EN;
    logic            req;
    logic            kick;
    logic [N_CH-1:0] rst, rst0;
    logic            busy, busy0;
    logic            done, done0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t got_exp;

    always #5 clk_in = ~clk_in;

    reset_seq #(
        .N_CH(N_CH), .CNT_W(CNT_W), .DELAY(DELAY),
        .PULSE(PULSE), .STAGGER(STAGGER), .WDOG(WDOG)
    ) u_dut (
        .clk_in(clk_in), .rst_n(rst_n), .EN(EN), .req(req), .kick(kick),
        .rst(rst), .busy(busy), .done(done)
    );

    reset_seq #(
        .N_CH(N_CH), .CNT_W(CNT_W), .DELAY(DELAY),
        .PULSE(PULSE), .STAGGER(0), .WDOG(WDOG)
    ) u_dut_s0 (
        .clk_in(clk_in), .rst_n(rst_n), .EN(EN), .req(req), .kick(kick),
        .rst(rst0), .busy(busy0), .done(done0)
    );

    // rel = edges since the edge that asserted all channels (negative: not yet asserted).
    function automatic exp_t model(input int rel, input int stg);
        exp_t m;
        int   last;
        last = PULSE + (N_CH - 1) * stg;
        for (int k = 0; k < N_CH; k++) begin
            m.rst[k] = (rel >= 0) && (rel < PULSE + k * stg);
        end
        m.busy = (rel >= 0) && (rel < last);
        m.done = (rel >= last);
        return m;
    endfunction

    task automatic start_fresh();
        rst_n = 1'b0;
        EN    = 1'b1;
        req   = 1'b0;
        kick  = 1'b0;
        @(posedge clk_in); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; EN = 1'b1; req = 1'b1; kick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL reset i=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         i, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_powerup();
        start_fresh();
        for (int e = 0; e <= 30; e++) begin
            req = (e == 3);
            exp_q.push_back(model(e - DELAY, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL powerup e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_retrigger();
        start_fresh();
        for (int e = 0; e <= 35; e++) begin
            req = (e == 21) || (e == 23);
            exp_q.push_back((e < 21) ? model(e - DELAY, STAGGER) : model(e - 21, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL retrigger e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_en_drop();
        start_fresh();
        for (int e = 0; e <= 16; e++) begin
            EN = (e < 15);
            exp_q.push_back((e < 15) ? model(e - DELAY, STAGGER) : exp_t'('0));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL en_drop e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        EN = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            exp_q.push_back(model(e - DELAY, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL en_restart e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
    endtask

    task automatic test_rst_priority();
        start_fresh();
        for (int e = 0; e <= 25; e++) begin
            rst_n = (e != 15);
            req   = (e == 15);
            exp_q.push_back((e < 15) ? model(e - DELAY, STAGGER) :
                            (e == 15) ? exp_t'('0) : model(e - 16 - DELAY, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL rst_priority e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        rst_n = 1'b1;
        req   = 1'b0;
    endtask

    task automatic test_stagger0();
        start_fresh();
        for (int e = 0; e <= 20; e++) begin
            exp_q.push_back(model(e - DELAY, 0));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst0, busy0, done0} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL stagger0 e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst0, busy0, done0, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
    endtask

`ifdef RESET_SEQ_WDOG_EN
    task automatic test_wdog();
        // Done at edge 17; watchdog expires WDOG edges later.
        start_fresh();
        for (int e = 0; e <= 50; e++) begin
            exp_q.push_back((e < 17 + WDOG) ? model(e - DELAY, STAGGER) : model(e - 17 - WDOG, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL wdog_fire e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        start_fresh();
        for (int e = 0; e <= 220; e++) begin
            kick = (e >= 17) && ((e - 17) % 10 == 0);
            exp_q.push_back(model(e - DELAY, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL wdog_kick e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
        kick = 1'b0;
    endtask
`else
    task automatic test_no_wdog();
        start_fresh();
        for (int e = 0; e <= 230; e++) begin
            exp_q.push_back(model(e - DELAY, STAGGER));
            @(posedge clk_in); #1;
            got_exp = exp_q.pop_front();
            checks++;
            if ({rst, busy, done} !== {got_exp.rst, got_exp.busy, got_exp.done}) begin
                errors++;
                $display("FAIL no_wdog e=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                         e, rst, busy, done, got_exp.rst, got_exp.busy, got_exp.done);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        EN    = 1'b1;
        req   = 1'b0;
        kick  = 1'b0;
        @(posedge clk_in); #1;
        test_reset();
        test_powerup();
        test_retrigger();
        test_en_drop();
        test_rst_priority();
        test_stagger0();
`ifdef RESET_SEQ_WDOG_EN
        test_wdog();
`else
        test_no_wdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
